// File: rtl/goomba_sprite_fetch_if.sv
// Signal bundle between the Goomba sprite fetch stage and its surroundings
// (game logic, VGA timing, sprite ROM mux, frame compositor).
interface goomba_sprite_fetch_if;
  logic        frame_start;
  logic        spawn;
  logic        stomp;
  logic [9:0]  PosX;
  logic [9:0]  PosY;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [8:0]  read_address;
  logic        rom_sel;
  logic        walk_frame;
  logic [11:0] rom_color;
  logic [11:0] pixel_color;
  logic        pixel_on;
  logic [1:0]  state;

  modport master (
    output frame_start, spawn, stomp, PosX, PosY, DrawX, DrawY, rom_color,
    input  read_address, rom_sel, walk_frame, pixel_color, pixel_on, state
  );

  modport slave (
    input  frame_start, spawn, stomp, PosX, PosY, DrawX, DrawY, rom_color,
    output read_address, rom_sel, walk_frame, pixel_color, pixel_on, state
  );
endinterface

// File: rtl/goomba_sprite_fetch.sv
// Goomba life-state FSM, beam-to-ROM address mapping and a two-stage
// transparency-keyed pixel pipeline feeding the frame compositor.
module goomba_sprite_fetch #(
  parameter int          SPRITE_W      = 21,
  parameter int          SPRITE_H      = 21,
  parameter int          SQUISH_FRAMES = 30,
  parameter int          ANIM_FRAMES   = 8,
  parameter logic [11:0] TRANSPARENT   = 12'h808
) (
  input logic                  Clk,
  input logic                  Reset_n,
  goomba_sprite_fetch_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_WALK   = 2'b01,
    S_SQUISH = 2'b10
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_timer, w_timer_nxt;
  logic [7:0]  r_anim, w_anim_nxt;
  logic        r_walk, w_walk_nxt;

  logic [8:0]  r_addr;
  logic        r_sel;
  logic        r_v1;
  logic        r_pix_on;
  logic [11:0] r_pix_col;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= S_IDLE;
      r_timer <= 8'd0;
      r_anim  <= 8'd0;
      r_walk  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_anim  <= w_anim_nxt;
      r_walk  <= w_walk_nxt;
    end
  end

  // A stomp pre-empts a coincident frame_start, so no animation step is taken.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_anim_nxt  = r_anim;
    w_walk_nxt  = r_walk;
    case (r_state)
      S_IDLE: begin
        if (bus.spawn) begin
          w_state_nxt = S_WALK;
          w_anim_nxt  = 8'd0;
          w_walk_nxt  = 1'b0;
        end
      end
      S_WALK: begin
        if (bus.stomp) begin
          w_state_nxt = S_SQUISH;
          w_timer_nxt = 8'(SQUISH_FRAMES);
        end else if (bus.frame_start) begin
          if (r_anim == 8'(ANIM_FRAMES - 1)) begin
            w_anim_nxt = 8'd0;
            w_walk_nxt = ~r_walk;
          end else begin
            w_anim_nxt = r_anim + 8'd1;
          end
        end
      end
      S_SQUISH: begin
        if (bus.frame_start) begin
          if (r_timer == 8'd1) begin
            w_state_nxt = S_IDLE;
            w_timer_nxt = 8'd0;
          end else begin
            w_timer_nxt = r_timer - 8'd1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_timer_nxt = 8'd0;
      end
    endcase
  end

  // Box edges are widened to 11 bits so a sprite near X=1023 cannot wrap.
  logic [10:0] w_x_end, w_y_end;
  logic        w_in_box;
  logic [9:0]  w_dx, w_dy, w_addr;

  assign w_x_end  = {1'b0, bus.PosX} + 11'(SPRITE_W);
  assign w_y_end  = {1'b0, bus.PosY} + 11'(SPRITE_H);
  assign w_in_box = (bus.DrawX >= bus.PosX) && ({1'b0, bus.DrawX} < w_x_end) &&
                    (bus.DrawY >= bus.PosY) && ({1'b0, bus.DrawY} < w_y_end) &&
                    (r_state != S_IDLE);
  assign w_dx     = bus.DrawX - bus.PosX;
  assign w_dy     = bus.DrawY - bus.PosY;
  assign w_addr   = w_dy * 10'(SPRITE_W) + w_dx;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_addr <= 9'd0;
      r_sel  <= 1'b0;
      r_v1   <= 1'b0;
    end else begin
      r_addr <= w_in_box ? w_addr[8:0] : 9'd0;
      r_sel  <= (r_state == S_SQUISH);
      r_v1   <= w_in_box;
    end
  end

  logic w_opaque;
  assign w_opaque = r_v1 && (bus.rom_color != TRANSPARENT);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_pix_on  <= 1'b0;
      r_pix_col <= 12'd0;
    end else begin
      r_pix_on  <= w_opaque;
      r_pix_col <= w_opaque ? bus.rom_color : 12'd0;
    end
  end

  assign bus.read_address = r_addr;
  assign bus.rom_sel      = r_sel;
  assign bus.walk_frame   = r_walk;
  assign bus.pixel_on     = r_pix_on;
  assign bus.pixel_color  = r_pix_col;
  assign bus.state        = r_state;

endmodule

// File: tb/tb_goomba_sprite_fetch.sv
// Self-checking bench for goomba_sprite_fetch: life-state FSM, address map,
// transparency keying and pipeline latency against a scoreboard.
module tb_goomba_sprite_fetch;

  logic Clk;
  logic Reset_n;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   pos_x = 0;
  int   pos_y = 0;
  bit   force_en = 0;
  logic [11:0] force_val = 12'h000;

  logic [12:0] exp_q[$];
  int          cyc_q[$];

  goomba_sprite_fetch_if bus();

  goomba_sprite_fetch dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  // Sprite ROM stand-in: distinct colour per address and bank, never 12'h808.
  function automatic logic [11:0] rom_model(input logic [8:0] a, input logic s);
    return {s, 2'b01, a};
  endfunction

  assign bus.rom_color = force_en ? force_val : rom_model(bus.read_address, bus.rom_sel);

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Drive one beam position, score the pixel from two cycles earlier, and
  // check stage-1 address/bank one cycle later.
  task automatic pix_cycle(input int x, input int y, input logic [1:0] st, input bit push);
    logic        inb;
    logic [8:0]  ea;
    logic [11:0] col;
    logic        on;
    logic [12:0] exp_v;
    if (exp_q.size() > 0 && cyc_q[0] <= cyc - 2) begin
      exp_v = exp_q.pop_front();
      void'(cyc_q.pop_front());
      total++;
      if ({bus.pixel_on, bus.pixel_color} !== exp_v) begin
        bad++;
        $display("FAIL pixel cyc=%0d got on=%b col=%h want on=%b col=%h",
                 cyc, bus.pixel_on, bus.pixel_color, exp_v[12], exp_v[11:0]);
      end
    end
    bus.DrawX = 10'(x);
    bus.DrawY = 10'(y);
    inb = (x >= pos_x) && (x < pos_x + 21) && (y >= pos_y) && (y < pos_y + 21) && (st != 2'b00);
    ea  = inb ? 9'((y - pos_y) * 21 + (x - pos_x)) : 9'd0;
    col = force_en ? force_val : rom_model(ea, st == 2'b10);
    on  = inb && (col != 12'h808);
    if (push) begin
      exp_q.push_back({on, on ? col : 12'h000});
      cyc_q.push_back(cyc);
    end
    @(negedge Clk);
    cyc++;
    total++;
    if (bus.read_address !== ea || bus.rom_sel !== (st == 2'b10)) begin
      bad++;
      $display("FAIL addr x=%0d y=%0d got addr=%0d sel=%b want addr=%0d sel=%b",
               x, y, bus.read_address, bus.rom_sel, ea, st == 2'b10);
    end
  endtask

  task automatic flush(input logic [1:0] st);
    pix_cycle(1023, 1023, st, 0);
    pix_cycle(1023, 1023, st, 0);
  endtask

  task automatic pulse(input bit sp, input bit sm, input bit fs);
    bus.spawn = sp;
    bus.stomp = sm;
    bus.frame_start = fs;
    @(negedge Clk);
    bus.spawn = 1'b0;
    bus.stomp = 1'b0;
    bus.frame_start = 1'b0;
    @(negedge Clk);
  endtask

  task automatic set_pos(input int x, input int y);
    pos_x = x;
    pos_y = y;
    bus.PosX = 10'(x);
    bus.PosY = 10'(y);
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    bus.spawn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      total++;
      if (bus.state !== 2'b00 || bus.pixel_on !== 1'b0 || bus.read_address !== 9'd0 ||
          bus.walk_frame !== 1'b0 || bus.rom_sel !== 1'b0 || bus.pixel_color !== 12'd0) begin
        bad++;
        $display("FAIL reset_hold st=%b on=%b addr=%0d wf=%b sel=%b col=%h want all zero",
                 bus.state, bus.pixel_on, bus.read_address, bus.walk_frame, bus.rom_sel, bus.pixel_color);
      end
    end
    bus.spawn = 1'b0;
    Reset_n = 1'b1;
    @(negedge Clk);
    total++;
    if (bus.state !== 2'b00) begin
      bad++;
      $display("FAIL reset_release st=%b want 00", bus.state);
    end
    pulse(1, 0, 0);
    total++;
    if (bus.state !== 2'b01) begin
      bad++;
      $display("FAIL spawn st=%b want 01", bus.state);
    end
  endtask

  task automatic test_address();
    set_pos(100, 50);
    pix_cycle(100, 50, 2'b01, 1);
    pix_cycle(120, 70, 2'b01, 1);
    pix_cycle(121, 70, 2'b01, 1);
    pix_cycle(110, 60, 2'b01, 1);
    pix_cycle(99, 55, 2'b01, 1);
    pix_cycle(105, 49, 2'b01, 1);
    pix_cycle(100, 71, 2'b01, 1);
    for (int i = 0; i < 6; i++)
      pix_cycle(100 + $urandom_range(0, 24), 48 + $urandom_range(0, 24), 2'b01, 1);
    flush(2'b01);
  endtask

  task automatic test_transparency();
    set_pos(100, 50);
    force_en = 1'b1;
    force_val = 12'h808;
    pix_cycle(105, 55, 2'b01, 1);
    pix_cycle(106, 55, 2'b01, 1);
    flush(2'b01);
    force_val = 12'hE51;
    pix_cycle(90, 55, 2'b01, 1);
    pix_cycle(105, 55, 2'b01, 1);
    pix_cycle(90, 55, 2'b01, 1);
    pix_cycle(120, 70, 2'b01, 1);
    flush(2'b01);
    force_en = 1'b0;
  endtask

  task automatic test_anim_edge();
    for (int i = 0; i < 8; i++) pulse(0, 0, 1);
    total++;
    if (bus.walk_frame !== 1'b1) begin
      bad++;
      $display("FAIL anim8 wf=%b want 1", bus.walk_frame);
    end
    for (int i = 0; i < 8; i++) pulse(0, 0, 1);
    total++;
    if (bus.walk_frame !== 1'b0 || bus.state !== 2'b01) begin
      bad++;
      $display("FAIL anim16 wf=%b st=%b want wf=0 st=01", bus.walk_frame, bus.state);
    end
    set_pos(630, 100);
    pix_cycle(640, 105, 2'b01, 1);
    pix_cycle(650, 105, 2'b01, 1);
    pix_cycle(651, 105, 2'b01, 1);
    pix_cycle(5, 105, 2'b01, 1);
    pix_cycle(629, 105, 2'b01, 1);
    flush(2'b01);
  endtask

  task automatic test_squish();
    set_pos(100, 50);
    pulse(0, 1, 0);
    total++;
    if (bus.state !== 2'b10 || bus.rom_sel !== 1'b1) begin
      bad++;
      $display("FAIL stomp st=%b sel=%b want st=10 sel=1", bus.state, bus.rom_sel);
    end
    pix_cycle(100, 50, 2'b10, 1);
    pix_cycle(115, 62, 2'b10, 1);
    pix_cycle(130, 62, 2'b10, 1);
    flush(2'b10);
    for (int i = 0; i < 29; i++) pulse(0, 0, 1);
    total++;
    if (bus.state !== 2'b10) begin
      bad++;
      $display("FAIL squish29 st=%b want 10", bus.state);
    end
    pulse(0, 0, 1);
    total++;
    if (bus.state !== 2'b00) begin
      bad++;
      $display("FAIL squish30 st=%b want 00", bus.state);
    end
    pix_cycle(100, 50, 2'b00, 1);
    pix_cycle(110, 60, 2'b00, 1);
    pix_cycle(120, 70, 2'b00, 1);
    flush(2'b00);
  endtask

  task automatic test_priority();
    pulse(0, 1, 0);
    total++;
    if (bus.state !== 2'b00) begin
      bad++;
      $display("FAIL stomp_idle st=%b want 00", bus.state);
    end
    pulse(1, 1, 0);
    total++;
    if (bus.state !== 2'b01 || bus.walk_frame !== 1'b0) begin
      bad++;
      $display("FAIL spawn_stomp st=%b wf=%b want st=01 wf=0", bus.state, bus.walk_frame);
    end
    for (int i = 0; i < 7; i++) pulse(0, 0, 1);
    pulse(0, 1, 1);
    total++;
    if (bus.state !== 2'b10 || bus.walk_frame !== 1'b0) begin
      bad++;
      $display("FAIL stomp_frame st=%b wf=%b want st=10 wf=0", bus.state, bus.walk_frame);
    end
    pulse(1, 0, 0);
    total++;
    if (bus.state !== 2'b10) begin
      bad++;
      $display("FAIL spawn_squish st=%b want 10", bus.state);
    end
  endtask

  initial begin
    Reset_n = 1'b0;
    bus.frame_start = 1'b0;
    bus.spawn = 1'b0;
    bus.stomp = 1'b0;
    bus.DrawX = 10'd1023;
    bus.DrawY = 10'd1023;
    set_pos(100, 50);
    test_reset();
    test_address();
    test_transparency();
    test_anim_edge();
    test_squish();
    test_priority();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
